// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: shares one ws2812 chain between the UI frame producer
// (port A) and the animation generator (port B). It arbitrates round-robin,
// latches the winning frame, pulses the chain start, enforces a minimum
// frame period and flags a chain that never reports done.
//
//   state  | meaning
//   -------+------------------------------------------
//   S_IDLE | waiting for a request and an open period
//   S_WAIT | frame in flight on the chain
module ws2812_frame_sched #(
   parameter int NUM_LEDS       = 16,
   parameter int FRAME_PERIOD   = 2_083_333,
   parameter int TIMEOUT_CYCLES = 200_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               i_req,
   input  logic [NUM_LEDS*24-1:0]   i_frame_a,
   input  logic [NUM_LEDS*24-1:0]   i_frame_b,
   output logic [1:0]               o_ack,
   output logic [NUM_LEDS*24-1:0]   o_chain_data,
   output logic                     o_chain_start,
   input  logic                     i_chain_done,
   output logic                     o_busy,
   output logic                     o_timeout_err,
   input  logic                     i_clear_err,
   output logic [15:0]              o_frame_count
);

   localparam int FW = NUM_LEDS * 24;
   localparam int PW = $clog2(FRAME_PERIOD + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] PER_MAX  = PW'(FRAME_PERIOD);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic [PW-1:0]   r_per_cnt;
   logic [TW-1:0]   r_wait_cnt;
   logic            r_last_grant;
   logic [1:0]      r_ack;
   logic [FW-1:0]   r_chain_data;
   logic            r_chain_start;
   logic            r_busy;
   logic            r_timeout_err;
   logic [15:0]     r_frame_count;

   logic            w_period_ok;
   logic            w_fire;
   logic            w_grant;
   logic            w_done;
   logic            w_timeout;

   // Next-state, grant selection and frame-end detection.
   always_comb begin
      w_next_state = r_state;
      w_fire       = 1'b0;
      w_grant      = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      w_period_ok  = (r_per_cnt == PER_MAX);
      case (r_state)
         S_IDLE: begin
            if ((i_req != 2'b00) && w_period_ok) begin
               w_fire       = 1'b1;
               w_next_state = S_WAIT;
               case (i_req)
                  2'b01:   w_grant = 1'b0;
                  2'b10:   w_grant = 1'b1;
                  default: w_grant = ~r_last_grant;
               endcase
            end
         end
         S_WAIT: begin
            // done takes priority over a timeout landing in the same cycle
            if (i_chain_done) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end else if (r_wait_cnt == TMO_LAST) begin
               w_timeout    = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Frame period limiter: restarts at each start, saturates at the period.
   // Resetting to the full period lets the first frame go out immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_per_cnt <= PER_MAX;
      else if (w_fire)              r_per_cnt <= '0;
      else if (r_per_cnt != PER_MAX) r_per_cnt <= r_per_cnt + PW'(1);
   end

   // Cycles spent waiting for the chain to finish the current frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_wait_cnt <= '0;
      else if (w_fire)           r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
   end

   // Grant side: latch the frame, ack the winner and pulse the chain start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack         <= 2'b00;
         r_chain_start <= 1'b0;
         r_chain_data  <= '0;
         r_last_grant  <= 1'b1;
      end else begin
         r_ack         <= 2'b00;
         r_chain_start <= w_fire;
         if (w_fire) begin
            r_ack[w_grant] <= 1'b1;
            r_chain_data   <= w_grant ? i_frame_b : i_frame_a;
            r_last_grant   <= w_grant;
         end
      end
   end

   // Status: busy flag, sticky timeout error and completed-frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         r_busy <= (w_next_state == S_WAIT);
         if (w_timeout)        r_timeout_err <= 1'b1;
         else if (i_clear_err) r_timeout_err <= 1'b0;
         if (w_done)           r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign o_ack         = r_ack;
   assign o_chain_data  = r_chain_data;
   assign o_chain_start = r_chain_start;
   assign o_busy        = r_busy;
   assign o_timeout_err = r_timeout_err;
   assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Bench for ws2812_frame_sched: directed sequences, a grant table and a
// randomized phase, all checked against a frame-level reference model.
module tb_ws2812_frame_sched;

   localparam int NL = 2;
   localparam int FP = 100;
   localparam int TO = 50;
   localparam int FW = NL * 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    i_req = 2'b00;
   logic [FW-1:0] i_frame_a = '0;
   logic [FW-1:0] i_frame_b = '0;
   logic [1:0]    o_ack;
   logic [FW-1:0] o_chain_data;
   logic          o_chain_start;
   logic          i_chain_done = 1'b0;
   logic          o_busy;
   logic          o_timeout_err;
   logic          i_clear_err = 1'b0;
   logic [15:0]   o_frame_count;

   ws2812_frame_sched #(.NUM_LEDS(NL), .FRAME_PERIOD(FP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_frame_a(i_frame_a), .i_frame_b(i_frame_b),
      .o_ack(o_ack), .o_chain_data(o_chain_data), .o_chain_start(o_chain_start),
      .i_chain_done(i_chain_done), .o_busy(o_busy), .o_timeout_err(o_timeout_err),
      .i_clear_err(i_clear_err), .o_frame_count(o_frame_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // chain model: chain_dly > 0 pulses done that many cycles after start,
   // 0 never answers, -1 drives random done pulses (1 in done_div)
   int chain_dly = 20;
   int ch_cnt    = -1;
   int done_div  = 16;

   // reference model: expected outputs plus frame-level bookkeeping
   logic [1:0]    e_ack;
   logic          e_start, e_busy, e_err;
   logic [FW-1:0] e_data;
   logic [15:0]   e_count;
   logic          m_last;
   int            m_since;     // cycles elapsed since the last start
   int            m_inflight;  // cycles the current frame has been waiting

   typedef struct {
      logic [1:0]    req;
      logic [FW-1:0] fa;
      logic [FW-1:0] fb;
      logic [1:0]    exp_ack;
      logic [FW-1:0] exp_data;
      logic [15:0]   exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      e_ack = 2'b00; e_start = 1'b0; e_busy = 1'b0; e_err = 1'b0;
      e_data = '0; e_count = 16'd0; m_last = 1'b1;
      m_since = FP; m_inflight = 0;
   endtask

   // Predict the outputs after the coming clock edge from the current inputs.
   task automatic model_step();
      logic g;
      logic tmo;
      if (rst) begin
         model_reset();
         return;
      end
      e_ack = 2'b00;
      e_start = 1'b0;
      tmo = 1'b0;
      if (!e_busy) begin
         if (i_req != 2'b00 && m_since >= FP) begin
            if (i_req == 2'b11) g = ~m_last;
            else                g = i_req[1];
            e_ack = g ? 2'b10 : 2'b01;
            e_start = 1'b1;
            e_data = g ? i_frame_b : i_frame_a;
            m_last = g;
            m_since = 0;
            m_inflight = 0;
            e_busy = 1'b1;
         end else if (m_since < FP) m_since++;
      end else begin
         if (m_since < FP) m_since++;
         if (i_chain_done) begin
            e_count = e_count + 16'd1;
            e_busy = 1'b0;
         end else if (m_inflight + 1 == TO) begin
            tmo = 1'b1;
            e_busy = 1'b0;
         end else m_inflight++;
      end
      if (tmo)              e_err = 1'b1;
      else if (i_clear_err) e_err = 1'b0;
   endtask

   // One clock: predict, advance to the falling edge, compare, drive chain done.
   task automatic cycle();
      model_step();
      @(negedge clk);
      cyc++;
      chk("m_ack",   64'(o_ack),         64'(e_ack));
      chk("m_start", 64'(o_chain_start), 64'(e_start));
      chk("m_data",  64'(o_chain_data),  64'(e_data));
      chk("m_busy",  64'(o_busy),        64'(e_busy));
      chk("m_err",   64'(o_timeout_err), 64'(e_err));
      chk("m_count", 64'(o_frame_count), 64'(e_count));
      if (rst) begin
         i_chain_done = 1'b0;
         ch_cnt = -1;
      end else if (chain_dly < 0) begin
         i_chain_done = ($urandom_range(done_div - 1) == 0);
      end else begin
         if (o_chain_start)  ch_cnt = 0;
         else if (ch_cnt >= 0) ch_cnt++;
         i_chain_done = (chain_dly > 0 && ch_cnt == chain_dly);
      end
   endtask

   task automatic wait_start(input string nm, input int bound);
      for (int k = 0; k < bound && !o_chain_start; k++) cycle();
      chk({nm, "_start_seen"}, 64'(o_chain_start), 64'd1);
   endtask

   task automatic wait_idle(input string nm, input int bound);
      for (int k = 0; k < bound && o_busy; k++) cycle();
      chk({nm, "_idle_seen"}, 64'(o_busy), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      logic [63:0] t;

      vecs[0] = '{req:2'b11, fa:48'h0A0B0C_0D0E0F, fb:48'hF0E0D0_C0B0A0, exp_ack:2'b10, exp_data:48'hF0E0D0_C0B0A0, exp_cnt:16'd3};
      vecs[1] = '{req:2'b11, fa:48'h123456_789ABC, fb:48'hFEDCBA_987654, exp_ack:2'b01, exp_data:48'h123456_789ABC, exp_cnt:16'd4};
      vecs[2] = '{req:2'b11, fa:48'h00FF00_FF00FF, fb:48'h5A5A5A_A5A5A5, exp_ack:2'b10, exp_data:48'h5A5A5A_A5A5A5, exp_cnt:16'd5};
      vecs[3] = '{req:2'b11, fa:48'h111111_222222, fb:48'h333333_444444, exp_ack:2'b01, exp_data:48'h111111_222222, exp_cnt:16'd6};
      vecs[4] = '{req:2'b10, fa:48'hAAAAAA_BBBBBB, fb:48'hCCCCCC_DDDDDD, exp_ack:2'b10, exp_data:48'hCCCCCC_DDDDDD, exp_cnt:16'd7};
      vecs[5] = '{req:2'b01, fa:48'h010203_040506, fb:48'h070809_0A0B0C, exp_ack:2'b01, exp_data:48'h010203_040506, exp_cnt:16'd8};

      // reset state
      model_reset();
      repeat (3) cycle();
      rst = 1'b0;
      chk("rst_ack",   64'(o_ack), 64'd0);
      chk("rst_start", 64'(o_chain_start), 64'd0);
      chk("rst_busy",  64'(o_busy), 64'd0);
      chk("rst_data",  64'(o_chain_data), 64'd0);
      chk("rst_count", 64'(o_frame_count), 64'd0);

      // single request after reset, no period delay
      chain_dly = 20;
      i_frame_a = 48'hFF0000_00FF00;
      i_req = 2'b01;
      cycle();
      s = cyc;
      chk("single_ack",   64'(o_ack), 64'd1);
      chk("single_start", 64'(o_chain_start), 64'd1);
      chk("single_data",  64'(o_chain_data), 64'hFF0000_00FF00);
      chk("single_busy",  64'(o_busy), 64'd1);
      i_req = 2'b00;
      wait_idle("single", 60);
      chk("single_busy_fall", 64'(cyc - s), 64'd21);
      chk("single_count", 64'(o_frame_count), 64'd1);

      // period limit: immediate re-request waits out the frame period
      i_req = 2'b01;
      wait_start("period", 200);
      chk("period_gap", 64'(cyc - s), 64'd101);
      i_req = 2'b00;
      wait_idle("period", 60);
      chk("period_count", 64'(o_frame_count), 64'd2);

      // grant table: ties alternate, single requests always win
      foreach (vecs[i]) begin
         i_frame_a = vecs[i].fa;
         i_frame_b = vecs[i].fb;
         i_req = vecs[i].req;
         for (int k = 0; k < 250 && o_ack == 2'b00; k++) cycle();
         chk("tbl_ack",  64'(o_ack), 64'(vecs[i].exp_ack));
         chk("tbl_data", 64'(o_chain_data), 64'(vecs[i].exp_data));
         i_req = 2'b00;
         wait_idle("tbl", 60);
         chk("tbl_count", 64'(o_frame_count), 64'(vecs[i].exp_cnt));
      end

      // timeout: chain never answers
      chain_dly = 0;
      i_req = 2'b01;
      wait_start("tmo", 200);
      s = cyc;
      i_req = 2'b00;
      wait_idle("tmo", 100);
      chk("tmo_delay", 64'(cyc - s), 64'd50);
      chk("tmo_err",   64'(o_timeout_err), 64'd1);
      chk("tmo_count", 64'(o_frame_count), 64'd8);
      cycle();
      chk("tmo_sticky", 64'(o_timeout_err), 64'd1);
      i_clear_err = 1'b1;
      cycle();
      i_clear_err = 1'b0;
      chk("tmo_clear", 64'(o_timeout_err), 64'd0);

      // done lands on the last allowed cycle: done wins
      chain_dly = 49;
      i_frame_b = 48'hBEEF00_00BEEF;
      i_req = 2'b10;
      wait_start("coll", 200);
      s = cyc;
      chk("coll_data", 64'(o_chain_data), 64'hBEEF00_00BEEF);
      i_req = 2'b00;
      wait_idle("coll", 100);
      chk("coll_delay", 64'(cyc - s), 64'd50);
      chk("coll_err",   64'(o_timeout_err), 64'd0);
      chk("coll_count", 64'(o_frame_count), 64'd9);

      // reset ten cycles into a frame
      chain_dly = 20;
      i_req = 2'b01;
      wait_start("mid", 200);
      i_req = 2'b00;
      repeat (10) cycle();
      rst = 1'b1;
      #1;
      chk("mid_ack",   64'(o_ack), 64'd0);
      chk("mid_start", 64'(o_chain_start), 64'd0);
      chk("mid_busy",  64'(o_busy), 64'd0);
      chk("mid_err",   64'(o_timeout_err), 64'd0);
      chk("mid_data",  64'(o_chain_data), 64'd0);
      chk("mid_count", 64'(o_frame_count), 64'd0);
      model_reset();
      i_chain_done = 1'b0;
      ch_cnt = -1;
      repeat (2) cycle();
      rst = 1'b0;
      i_frame_a = 48'hC0FFEE_123123;
      i_frame_b = 48'hDEAD00_456456;
      i_req = 2'b11;
      cycle();
      chk("mid_regrant_ack",   64'(o_ack), 64'd1);
      chk("mid_regrant_start", 64'(o_chain_start), 64'd1);
      chk("mid_regrant_data",  64'(o_chain_data), 64'hC0FFEE_123123);
      i_req = 2'b00;
      wait_idle("mid", 60);

      // randomized traffic against the reference model
      chain_dly = -1;
      for (int n = 0; n < 4000; n++) begin
         done_div = (n < 2000) ? 16 : 64;
         for (int b = 0; b < 2; b++) begin
            if (i_req[b]) begin
               if (o_ack[b] || $urandom_range(15) == 0) i_req[b] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               t = {$urandom(), $urandom()};
               if (b == 0) i_frame_a = t[FW-1:0];
               else        i_frame_b = t[FW-1:0];
               i_req[b] = 1'b1;
            end
         end
         i_clear_err = ($urandom_range(15) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_sched.md
# ws2812_frame_sched

Frame scheduler that shares one `ws2812_chain` between two frame producers: the rotary-FSM UI layer on port A and the animation generator on port B. It arbitrates between them round-robin, latches the winning frame into a stable register, and issues the chain `start` pulse. It also caps the refresh rate at a minimum frame period and flags a chain that never reports `done`. It sits directly between the producers and the chain instance.

## Interface
- `NUM_LEDS`, default 16: LEDs per frame. The frame width is `NUM_LEDS*24`, with LED 0 in the MSB 24 bits.
- `FRAME_PERIOD`, default 2_083_333: minimum clk cycles between consecutive `chain_start` pulses (60 Hz at 125 MHz).
- `TIMEOUT_CYCLES`, default 200_000: maximum cycles to wait for `chain_done` after `chain_start`.
- `clk` in, 1: system clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `req` in, 2: `req[0]` is port A, `req[1]` is port B. Each is held high until acked.
- `frame_a` in, `NUM_LEDS*24`: port A frame. Must be stable while `req[0]` is high.
- `frame_b` in, `NUM_LEDS*24`: port B frame. Must be stable while `req[1]` is high.
- `ack` out, 2: one-cycle pulse marking the cycle the requester's frame was latched.
- `chain_data` out, `NUM_LEDS*24`: registered frame, connected to chain `led_data`.
- `chain_start` out, 1: one-cycle pulse, connected to chain `start`.
- `chain_done` in, 1: connected to chain `done`.
- `busy` out, 1: high while in S_WAIT.
- `timeout_err` out, 1: sticky timeout flag.
- `clear_err` in, 1: synchronous clear of `timeout_err`.
- `frame_count` out, 16: count of completed frames. Wraps at 0xFFFF to 0.

## Operation
- States:
  - S_IDLE: waiting for a request.
  - S_WAIT: frame in flight on the chain.
- Period counter `per_cnt`:
  - Width is clog2(FRAME_PERIOD+1).
  - Cleared to 0 on the cycle `chain_start` is issued; otherwise increments and saturates at FRAME_PERIOD.
  - Reset value is FRAME_PERIOD, so the first frame after reset is not delayed.
  - `period_ok` = (`per_cnt` == FRAME_PERIOD).
- S_IDLE → S_WAIT when `req` != 0 and `period_ok`. On that clock edge:
  - `chain_data` loads the granted frame.
  - `ack[g]` = 1 for the granted port g.
  - `chain_start` = 1.
  - `last_grant` = g.
  - `wait_cnt` = 0.
- Arbitration:
  - If only one `req` bit is set, that port is granted.
  - If both are set, the port not equal to `last_grant` is granted.
  - `last_grant` resets to 1, so port A wins the first tie.
- S_WAIT:
  - `wait_cnt` increments every cycle. Width is clog2(TIMEOUT_CYCLES+1).
  - On `chain_done`: increment `frame_count` and go to S_IDLE.
  - Else, when `wait_cnt` == TIMEOUT_CYCLES-1: set `timeout_err` and go to S_IDLE. `frame_count` is unchanged.
  - If `chain_done` and the timeout condition occur in the same cycle, `chain_done` wins and no error is flagged.
- `chain_done` while in S_IDLE is ignored.
- `req` bits are ignored while in S_WAIT. Requests stay pending, no ack is given, and they are not queued beyond the level `req`.
- A requester that drops `req` before its ack is simply not served.
- `clear_err`:
  - Clears `timeout_err` the next cycle.
  - If a timeout fires in the same cycle as `clear_err`, the set wins.
- `chain_data` holds its value between grants.
- Reset values, applied at any time including mid-frame:
  - State = S_IDLE.
  - `ack`, `chain_start`, `busy`, `timeout_err` = 0.
  - `chain_data` = 0.
  - `frame_count` = 0.
  - `per_cnt` = FRAME_PERIOD.
  - `wait_cnt` = 0.
  - `last_grant` = 1.
- The chain shares `rst`, so it is reset together with this block.

## Timing
- All outputs are registered.
- Grant latency: `req` high in cycle T with `period_ok` and state S_IDLE gives `ack`/`chain_start` high and `chain_data` valid in cycle T+1.
- `chain_data` and `chain_start` change on the same edge. The chain samples both together.
- `busy` rises in T+1 together with `chain_start`. It falls the cycle after `chain_done` is sampled.
- Earliest re-grant is the cycle after returning to S_IDLE, provided `period_ok`.
- Start-to-start spacing is ≥ FRAME_PERIOD+1 cycles.
- Timeout: with no `chain_done`, `timeout_err` and the return to S_IDLE occur TIMEOUT_CYCLES cycles after the `chain_start` cycle.

## Test plan
All scenarios use NUM_LEDS=2, FRAME_PERIOD=100, TIMEOUT_CYCLES=50, and a behavioural chain model that pulses done 20 cycles after start.
- **Single request after reset:** `req`=01, `frame_a`=0xFF0000_00FF00 → next cycle `ack`=01, `chain_start`=1, `chain_data`=0xFF0000_00FF00, `busy`=1; done 20 cycles later gives `frame_count`=1 and `busy`=0.
- **Period limit:** `req[0]` reasserted immediately after done → second `chain_start` occurs exactly 101 cycles after the first, not earlier.
- **Tie round-robin:** `req`=11 held continuously → grants alternate A, B, A, B across four frames; `chain_data` matches `frame_a`/`frame_b` respectively.
- **Timeout:** chain model never pulses done → `timeout_err`=1 and `busy`=0 exactly 50 cycles after `chain_start`, `frame_count` unchanged; `clear_err` pulse → `timeout_err`=0.
- **Done/timeout collision:** model pulses done on cycle 49 after start → `frame_count` increments and `timeout_err` stays 0.
- **Reset mid-frame:** assert `rst` 10 cycles into S_WAIT → all outputs return to their reset values, `frame_count`=0, and a new `req` is granted on the first cycle after reset release, with no period delay.
